javk_bus_ctrl: RTL
==================

// Module: javk_bus_ctrl
// PURPOSE
//  Sequences and arbitrates the single external memory bus (databus/addrbus/rw) of the JAVK CPU.
//  Two requesters share it: instruction fetch (IF, byte reads) and load/store (LS, 8/16-bit rd/wr).
//  Round-robin grant when both pend; 16-bit LS accesses split into two byte cycles, little-endian.
//  Sits between the core datapath and the top-level bus pins.
// PARAMETERS
//  ADDR_W    16  address width; addrbus, if_addr, ls_addr
//  LS_FIRST  1   rr pointer after reset: 1 = LS wins first tie, 0 = IF wins
// PORTS
//  clk        in    1       system clock; all state updates on rising edge
//  rst        in    1       synchronous, active-high reset
//  databus    inout 8       external data bus; driven only during LS write XFER, else 'z
//  addrbus    out   ADDR_W  external address, registered
//  rw         out   1       1 = read, 0 = write, registered
//  if_req     in    1       IF request, level; hold until if_gnt
//  if_addr    in    ADDR_W  IF byte address
//  if_gnt     out   1       1-cycle pulse: IF request accepted, inputs latched
//  if_done    out   1       1-cycle pulse: if_rdata valid
//  if_rdata   out   8       fetched byte, held until next IF done
//  ls_req     in    1       LS request, level; hold until ls_gnt
//  ls_we      in    1       1 = write
//  ls_wide    in    1       1 = 16-bit access (two bytes: addr, addr+1)
//  ls_addr    in    ADDR_W  LS base address
//  ls_wdata   in    16      write data; [7:0] -> addr, [15:8] -> addr+1
//  ls_gnt     out   1       1-cycle pulse: LS accepted, inputs latched
//  ls_done    out   1       1-cycle pulse: access complete, ls_rdata valid for reads
//  ls_rdata   out   16      read data; [15:8] = 0 for narrow reads; held until next LS done
// BEHAVIOUR
//  - Reset: state IDLE, addrbus 0, rw 1, databus 'z, all gnt/done 0, rdata 0, rr pointer per LS_FIRST.
//  - FSM: IDLE -> XFER0 -> [XFER1 if ls_wide] -> DONE -> IDLE.
//  - IDLE: sample reqs; one pending -> grant it; both -> grant per rr pointer, pointer flips to other.
//    Grant edge: latch addr/we/wide/wdata, pulse gnt next cycle, enter XFER0, drive addrbus/rw.
//  - XFER0: addrbus = addr, rw = ~we; write drives wdata[7:0]; read captures databus at cycle end.
//  - XFER1: addrbus = addr+1, ADDR_W-bit wrap (FFFF -> 0000); byte [15:8] likewise.
//  - DONE: done pulse for granted requester; databus 'z, rw 1; addrbus holds last value.
//  - Latency: narrow access 3 cycles grant-to-IDLE, wide 4; done exactly 1 cycle after last XFER.
//  - Req dropped before grant: no transfer. Req held through DONE: re-arbitrated as new request.
//  - IF requests with ls_we/ls_wide ignored; IF always narrow read.
//  - databus driven iff state in {XFER0,XFER1} and latched we=1; never driven in same cycle as rw=1.
//  - rst mid-transfer: abort at that edge, no done pulse, bus released (rw 1, 'z), pointer reset.
//  - Simultaneous gnt of both requesters impossible; assert in bench.
// CONFIGURATION
//  JAVK_BUS_WAIT_EN defined: extra input bus_ready (1 bit); XFER0/XFER1 repeat while bus_ready=0,
//    addrbus/rw/databus stable; read data captured on cycle with bus_ready=1; rst still aborts.
//  Undefined: no bus_ready port; each XFER exactly one cycle.
// TESTING
//  - IF-only read addr 0x1234, mem=0xA5 -> if_gnt, addrbus 0x1234 rw=1, if_done+if_rdata=0xA5, 3 cycles.
//  - LS wide write 0xBEEF to 0x2000 -> mem[0x2000]=0xEF, mem[0x2001]=0xBE, rw=0 2 cycles, ls_done.
//  - LS wide read at 0xFFFF, mem[FFFF]=0x11, mem[0000]=0x22 -> addrbus FFFF then 0000, ls_rdata=0x2211.
//  - if_req,ls_req both held 4 accesses, LS_FIRST=1 -> grant order LS,IF,LS,IF; never both gnt.
//  - rst during XFER1 of wide write -> no ls_done, rw=1, databus 'z next cycle, state IDLE.
//  - JAVK_BUS_WAIT_EN, bus_ready low 3 cycles on IF read -> addrbus held 4 cycles, if_done after ready.

Source files
------------

// File: rtl/javk_bus_ctrl.sv
// rtl/javk_bus_ctrl.sv - JAVK external memory bus sequencer and IF/LS round-robin arbiter
// Define JAVK_BUS_WAIT_EN to add the bus_ready input (XFER cycles stretch while it is low).
module javk_bus_ctrl #(
  parameter int ADDR_W   = 16,
  parameter bit LS_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [7:0]        databus,
  output logic [ADDR_W-1:0] addrbus,
  output logic              rw,
`ifdef JAVK_BUS_WAIT_EN
  input  logic              bus_ready,
`endif
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [7:0]        if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic              ls_wide,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [15:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [15:0]       ls_rdata
);

  typedef enum logic [1:0] {IDLE, XFER0, XFER1, DONE} state_t;

  state_t            state;
  logic              ptr;
  logic              sel_ls;
  logic              we_q;
  logic              wide_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        lo_q;
  logic              ready;
  logic              pick_ls;
  logic              drive;
  logic [7:0]        wbyte;

`ifdef JAVK_BUS_WAIT_EN
  assign ready = bus_ready;
`else
  assign ready = 1'b1;
`endif

  // ptr set means LS wins the next tie
  assign pick_ls = ls_req && (!if_req || ptr);

  assign drive   = we_q && (state == XFER0 || state == XFER1);
  assign wbyte   = (state == XFER1) ? wdata_q[15:8] : wdata_q[7:0];
  assign databus = drive ? wbyte : 8'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addrbus  <= '0;
      rw       <= 1'b1;
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_rdata <= 8'h00;
      ls_rdata <= 16'h0000;
      ptr      <= LS_FIRST;
      sel_ls   <= 1'b0;
      we_q     <= 1'b0;
      wide_q   <= 1'b0;
      wdata_q  <= 16'h0000;
      addr_q   <= '0;
      lo_q     <= 8'h00;
    end else begin
      if_gnt  <= 1'b0;
      ls_gnt  <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            if (if_req && ls_req) ptr <= !pick_ls;
            sel_ls <= pick_ls;
            state  <= XFER0;
            if (pick_ls) begin
              addr_q  <= ls_addr;
              we_q    <= ls_we;
              wide_q  <= ls_wide;
              wdata_q <= ls_wdata;
              ls_gnt  <= 1'b1;
              addrbus <= ls_addr;
              rw      <= !ls_we;
            end else begin
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              wide_q  <= 1'b0;
              if_gnt  <= 1'b1;
              addrbus <= if_addr;
              rw      <= 1'b1;
            end
          end
        end
        XFER0: begin
          if (ready) begin
            if (wide_q) begin
              state   <= XFER1;
              addrbus <= addr_q + ADDR_W'(1);
              lo_q    <= databus;
            end else begin
              state <= DONE;
              rw    <= 1'b1;
              if (sel_ls) begin
                ls_done <= 1'b1;
                if (!we_q) ls_rdata <= {8'h00, databus};
              end else begin
                if_done  <= 1'b1;
                if_rdata <= databus;
              end
            end
          end
        end
        XFER1: begin
          // only LS wide accesses reach the second byte
          if (ready) begin
            state   <= DONE;
            rw      <= 1'b1;
            ls_done <= 1'b1;
            if (!we_q) ls_rdata <= {databus, lo_q};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
